// File: rtl/cordic_post_if.sv
// cordic_post_if
// Bundles the three handshakes of the CORDIC post-stage: tag, result and output.
//   tag_valid/tag_ready/tag_in             : quadrant tags from the pre-stage
//   res_valid/res_ready/res_x/res_y/res_z  : raw CORDIC results
//   out_valid/out_ready/out_*              : restored results towards downstream
//   err_notag                              : sticky flag, result seen with no tag queued
// Modport "slave" is the post-stage itself; "master" is its environment.
interface cordic_post_if #(
    parameter int W = 16
);
    logic                tag_valid;
    logic                tag_ready;
    logic [2:0]          tag_in;
    logic                res_valid;
    logic                res_ready;
    logic signed [W-1:0] res_x;
    logic signed [W-1:0] res_y;
    logic signed [W-1:0] res_z;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_cos;
    logic signed [W-1:0] out_sin;
    logic signed [W-1:0] out_angle;
    logic                out_mode;
    logic                err_notag;

    modport slave (
        input  tag_valid, tag_in, res_valid, res_x, res_y, res_z, out_ready,
        output tag_ready, res_ready, out_valid, out_cos, out_sin, out_angle,
               out_mode, err_notag
    );

    modport master (
        output tag_valid, tag_in, res_valid, res_x, res_y, res_z, out_ready,
        input  tag_ready, res_ready, out_valid, out_cos, out_sin, out_angle,
               out_mode, err_notag
    );
endinterface

// File: rtl/cordic_post.sv
// cordic_post
// Output-side counterpart of the angle pre-conditioning stage. Quadrant tags
// issued by the pre-stage are queued in a small FIFO and paired, in order,
// with CORDIC results. The fold is then undone:
//   rotation (mode 0): quadrant swap/negate of (x, y) into (cos, sin)
//   vectoring (mode 1): quadrant offset added to the residual angle
// Results leave through a two-register valid/ready pipeline (fold stage,
// output stage), one result per cycle at full throughput.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : cordic_post_if.slave (tag, result and output handshakes, err flag)
module cordic_post #(
    parameter int TAG_DEPTH = 8,
    parameter int W         = 16,
    parameter int QUAD_STEP = 5760
) (
    input  logic         clk,
    input  logic         rst,
    cordic_post_if.slave bus
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    localparam logic [PW:0]           DEPTH_C  = (PW+1)'(TAG_DEPTH);
    localparam logic [PW:0]           CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic signed [W-1:0]   MIN_C    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]   MAX_C    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   ZERO_W   = {W{1'b0}};
    localparam logic signed [W+1:0]   ZERO_W2  = {(W+2){1'b0}};
    localparam logic signed [W+1:0]   STEP1    = (W+2)'(QUAD_STEP);
    localparam logic signed [W+1:0]   STEP2    = (W+2)'(2 * QUAD_STEP);
    localparam logic signed [W+1:0]   STEP3    = (W+2)'(3 * QUAD_STEP);
    localparam logic signed [W+1:0]   ANG_MAX  = (W+2)'(4 * QUAD_STEP - 1);

    // Saturating two's-complement negation: the most negative value has no
    // positive counterpart, so it maps to the most positive one.
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        if (v == MIN_C) begin
            r = MAX_C;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    // ---------------- tag FIFO ----------------
    logic [2:0]    tag_mem_r [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    // ---------------- pipeline ----------------
    logic                s1_valid_r;
    logic [2:0]          s1_tag_r;
    logic signed [W-1:0] s1_x_r;
    logic signed [W-1:0] s1_y_r;
    logic signed [W-1:0] s1_z_r;
    logic                s2_load_s;
    logic                s1_adv_s;
    logic                res_ready_s;

    logic                out_valid_r;
    logic signed [W-1:0] out_cos_r;
    logic signed [W-1:0] out_sin_r;
    logic signed [W-1:0] out_angle_r;
    logic                out_mode_r;
    logic                err_notag_r;

    logic signed [W-1:0] fold_cos_s;
    logic signed [W-1:0] fold_sin_s;
    logic signed [W-1:0] fold_ang_s;
    logic signed [W+1:0] base_s;
    logic signed [W+1:0] sum_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {(PW+1){1'b0}});

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push_s = bus.tag_valid && !full_s;

    // Output register frees up when empty or being drained this cycle.
    assign s2_load_s = !out_valid_r || bus.out_ready;
    assign s1_adv_s  = s1_valid_r && s2_load_s;

    // Uses the registered count, so a tag pushed this cycle is never bypassed
    // to a result arriving in the same cycle.
    assign res_ready_s = !empty_s && (!s1_valid_r || s1_adv_s);
    assign pop_s       = bus.res_valid && res_ready_s;

    // Tag storage write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 3'b000;
            end
        end else if (push_s) begin
            tag_mem_r[wr_ptr_r] <= bus.tag_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag: a result turned up with no tag to pair it with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_notag_r <= 1'b0;
        end else if (bus.res_valid && empty_s) begin
            err_notag_r <= 1'b1;
        end
    end

    // Stage 1: capture the raw result together with its popped tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_tag_r   <= 3'b000;
            s1_x_r     <= ZERO_W;
            s1_y_r     <= ZERO_W;
            s1_z_r     <= ZERO_W;
        end else if (!s1_valid_r || s1_adv_s) begin
            s1_valid_r <= pop_s;
            if (pop_s) begin
                s1_tag_r <= tag_mem_r[rd_ptr_r];
                s1_x_r   <= bus.res_x;
                s1_y_r   <= bus.res_y;
                s1_z_r   <= bus.res_z;
            end
        end
    end

    // Undo the quadrant fold on the stage-1 contents.
    always_comb begin
        fold_cos_s = ZERO_W;
        fold_sin_s = ZERO_W;
        fold_ang_s = ZERO_W;
        case (s1_tag_r[1:0])
            2'd1:    base_s = STEP1;
            2'd2:    base_s = STEP2;
            2'd3:    base_s = STEP3;
            default: base_s = ZERO_W2;
        endcase
        // Two guard bits keep the offset sum from wrapping before the clamp.
        sum_s = {{2{s1_z_r[W-1]}}, s1_z_r} + base_s;
        if (s1_tag_r[2]) begin
            fold_cos_s = s1_x_r;
            fold_sin_s = ZERO_W;
            if (s1_z_r[W-1]) begin
                // A negative residual means the true angle sits on the quadrant edge.
                fold_ang_s = base_s[W-1:0];
            end else if (sum_s > ANG_MAX) begin
                fold_ang_s = ANG_MAX[W-1:0];
            end else begin
                fold_ang_s = sum_s[W-1:0];
            end
        end else begin
            fold_ang_s = ZERO_W;
            case (s1_tag_r[1:0])
                2'd1: begin
                    fold_cos_s = neg_sat(s1_y_r);
                    fold_sin_s = s1_x_r;
                end
                2'd2: begin
                    fold_cos_s = neg_sat(s1_x_r);
                    fold_sin_s = neg_sat(s1_y_r);
                end
                2'd3: begin
                    fold_cos_s = s1_y_r;
                    fold_sin_s = neg_sat(s1_x_r);
                end
                default: begin
                    fold_cos_s = s1_x_r;
                    fold_sin_s = s1_y_r;
                end
            endcase
        end
    end

    // Stage 2: output registers, held steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_cos_r   <= ZERO_W;
            out_sin_r   <= ZERO_W;
            out_angle_r <= ZERO_W;
            out_mode_r  <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_cos_r   <= fold_cos_s;
                out_sin_r   <= fold_sin_s;
                out_angle_r <= fold_ang_s;
                out_mode_r  <= s1_tag_r[2];
            end
        end
    end

    assign bus.tag_ready = !full_s;
    assign bus.res_ready = res_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_cos   = out_cos_r;
    assign bus.out_sin   = out_sin_r;
    assign bus.out_angle = out_angle_r;
    assign bus.out_mode  = out_mode_r;
    assign bus.err_notag = err_notag_r;
endmodule

// File: tb/tb_cordic_post.sv
// tb_cordic_post
// Self-checking bench for cordic_post: a queue-based reference model of the
// tag pairing and fold undo, a per-cycle compare process, directed cases with
// literal expectations, and a randomized traffic phase.
module tb_cordic_post;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cordic_post_if #(.W(16)) bus ();

    cordic_post #(.TAG_DEPTH(8), .W(16), .QUAD_STEP(5760)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int cs;
        int sn;
        int ang;
        int md;
    } res_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int nsat(input int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    // Reference: what the restored result must be for a tag and a raw result.
    function automatic res_t model(input int tag, input int x, input int y, input int z);
        res_t r;
        int quad;
        quad = tag % 4;
        r.md = (tag / 4) % 2;
        r.cs = 0; r.sn = 0; r.ang = 0;
        if (r.md == 0) begin
            case (quad)
                0: begin r.cs = x;       r.sn = y;       end
                1: begin r.cs = nsat(y); r.sn = x;       end
                2: begin r.cs = nsat(x); r.sn = nsat(y); end
                default: begin r.cs = y; r.sn = nsat(x); end
            endcase
        end else begin
            r.cs = x;
            r.ang = (z < 0) ? quad * 5760 : z + quad * 5760;
            if (r.ang > 23039) r.ang = 23039;
        end
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    int   tagq[$];
    res_t expq[$];
    bit   err_m;
    bit   hold_p;
    res_t prev;
    int   accepted = 0;

    always @(negedge clk) begin
        int   sz0;
        res_t h;
        if (rst) begin
            tagq.delete();
            expq.delete();
            err_m  = 1'b0;
            hold_p = 1'b0;
        end else begin
            sz0 = tagq.size();
            check("tag_ready", int'(bus.tag_ready), (sz0 < 8) ? 1 : 0);
            check("err_notag", int'(bus.err_notag), int'(err_m));
            if (sz0 == 0) check("res_ready_empty", int'(bus.res_ready), 0);
            if (hold_p) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_cos", int'(bus.out_cos), prev.cs);
                check("hold_sin", int'(bus.out_sin), prev.sn);
                check("hold_angle", int'(bus.out_angle), prev.ang);
            end
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("out_valid_spurious", int'(bus.out_valid), 0);
                end else begin
                    h = expq[0];
                    check("out_cos", int'(bus.out_cos), h.cs);
                    check("out_sin", int'(bus.out_sin), h.sn);
                    check("out_angle", int'(bus.out_angle), h.ang);
                    check("out_mode", int'(bus.out_mode), h.md);
                    if (bus.out_ready) void'(expq.pop_front());
                end
            end
            hold_p  = bus.out_valid && !bus.out_ready;
            prev.cs = int'(bus.out_cos);
            prev.sn = int'(bus.out_sin);
            prev.ang = int'(bus.out_angle);
            prev.md = int'(bus.out_mode);
            if (bus.res_valid && bus.res_ready && sz0 > 0) begin
                expq.push_back(model(tagq.pop_front(), int'(bus.res_x),
                                     int'(bus.res_y), int'(bus.res_z)));
                accepted++;
            end
            if (bus.res_valid && sz0 == 0) err_m = 1'b1;
            if (bus.tag_valid && bus.tag_ready) tagq.push_back(int'(bus.tag_in));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [2:0] t);
        bus.tag_valid = 1'b1;
        bus.tag_in    = t;
        tick();
        bus.tag_valid = 1'b0;
    endtask

    // Holds one result until accepted (bounded); returns at accept edge + 1.
    task automatic offer(input int x, input int y, input int z);
        bit ok;
        ok = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_x = 16'(x);
        bus.res_y = 16'(y);
        bus.res_z = 16'(z);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = bus.res_ready;
            tick();
            if (ok) break;
        end
        bus.res_valid = 1'b0;
        if (!ok) check("offer_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input logic [2:0] tag,
                            input int x, input int y, input int z,
                            input int ecs, input int esn, input int eang, input int emd);
        push_tag(tag);
        offer(x, y, z);
        check({name, "_lat1"}, int'(bus.out_valid), 0);
        tick();
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_cos"}, int'(bus.out_cos), ecs);
        check({name, "_sin"}, int'(bus.out_sin), esn);
        check({name, "_angle"}, int'(bus.out_angle), eang);
        check({name, "_mode"}, int'(bus.out_mode), emd);
        repeat (2) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        int   k;
        int   cyc;
        bit   acc;

        rst = 1'b1;
        bus.tag_valid = 1'b0; bus.tag_in = 3'b000;
        bus.res_valid = 1'b0; bus.res_x = 16'sd0; bus.res_y = 16'sd0; bus.res_z = 16'sd0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_tag_ready", int'(bus.tag_ready), 1);
        check("rst_res_ready", int'(bus.res_ready), 0);
        check("rst_err", int'(bus.err_notag), 0);
        check("rst_cos", int'(bus.out_cos), 0);
        check("rst_angle", int'(bus.out_angle), 0);
        tick();
        rst = 1'b0;
        tick();

        // pin the reference model with hand-computed values
        m = model(1, 14189, 8192, 0);
        check("model_q1_cos", m.cs, -8192);
        check("model_q1_sin", m.sn, 14189);
        m = model(6, 0, 0, 2880);
        check("model_at_q2", m.ang, 14400);
        m = model(7, 0, 0, 6000);
        check("model_at_clamp", m.ang, 23039);
        m = model(2, -32768, 5, 0);
        check("model_sat", m.cs, 32767);

        // directed cases with literal expectations
        directed("rot_q0", 3'b000, 14189, 8192, 0, 14189, 8192, 0, 0);
        directed("rot_q1", 3'b001, 14189, 8192, 0, -8192, 14189, 0, 0);
        directed("rot_q3", 3'b011, 14189, 8192, 0, 8192, -14189, 0, 0);
        directed("at_q2", 3'b110, 5000, 0, 2880, 5000, 0, 14400, 1);
        directed("sat_q2", 3'b010, -32768, 100, 0, 32767, -100, 0, 0);
        directed("at_clamp", 3'b111, 7, 0, 6000, 7, 0, 23039, 1);
        directed("at_negz", 3'b101, 9, 0, -50, 9, 0, 5760, 1);

        // FIFO full: 9 pushes, the last must be refused
        bus.tag_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.tag_in = 3'(i);
            @(negedge clk);
            if (i == 8) check("fifo_full_ready", int'(bus.tag_ready), 0);
            tick();
        end
        bus.tag_valid = 1'b0;
        for (int i = 0; i < 8; i++) offer(1000 + i, -i, i * 10);
        repeat (4) tick();
        check("fifo_drained", expq.size(), 0);
        // result with nothing queued (also exposes a wrongly accepted 9th tag)
        bus.res_valid = 1'b1;
        @(negedge clk);
        check("notag_res_ready", int'(bus.res_ready), 0);
        tick();
        bus.res_valid = 1'b0;
        check("notag_err", int'(bus.err_notag), 1);
        repeat (3) tick();
        check("notag_sticky", int'(bus.err_notag), 1);
        pulse_reset();
        check("err_cleared", int'(bus.err_notag), 0);

        // backpressure: 4 offered over 5 stalled cycles, only 2 fit
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_tag(3'b000);
        k = 0;
        bus.res_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.res_x = 16'(100 * (k + 1)); bus.res_y = 16'(k); bus.res_z = 16'sd0;
            @(negedge clk);
            acc = bus.res_ready;
            tick();
            if (acc) k++;
        end
        bus.res_x = 16'(100 * (k + 1)); bus.res_y = 16'(k);
        check("bp_accepted", k, 2);
        check("bp_res_ready", int'(bus.res_ready), 0);
        check("bp_out_valid", int'(bus.out_valid), 1);
        check("bp_head_cos", int'(bus.out_cos), 100);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            bus.res_x = 16'(100 * (k + 1)); bus.res_y = 16'(k);
            @(negedge clk);
            acc = bus.res_ready;
            tick();
            if (acc) k++;
        end
        bus.res_valid = 1'b0;
        check("bp_all_accepted", k, 4);
        repeat (4) tick();
        check("bp_drained", expq.size(), 0);

        // throughput: 4 queued tags, 4 back-to-back results in 4 cycles
        for (int i = 0; i < 4; i++) push_tag(3'(i));
        k = 0; cyc = 0;
        bus.res_valid = 1'b1;
        while (k < 4 && cyc < 20) begin
            bus.res_x = 16'(k * 7 - 9); bus.res_y = 16'(k * 3 + 1); bus.res_z = 16'(k);
            @(negedge clk);
            acc = bus.res_ready;
            tick();
            cyc++;
            if (acc) k++;
        end
        bus.res_valid = 1'b0;
        check("throughput_cycles", cyc, 4);
        repeat (4) tick();

        // randomized traffic with random backpressure
        for (int c = 0; c < 1500; c++) begin
            bus.tag_valid = ($urandom_range(0, 2) != 0);
            bus.tag_in    = 3'($urandom_range(0, 7));
            bus.res_valid = ($urandom_range(0, 2) == 0);
            bus.res_x     = 16'($urandom_range(0, 65535));
            bus.res_y     = 16'($urandom_range(0, 65535));
            bus.res_z     = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) bus.res_x = 16'sh8000;
            if ($urandom_range(0, 7) == 0) bus.res_y = 16'sh8000;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.tag_valid = 1'b0;
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check("rand_drained", expq.size(), 0);
        check("rand_accepted_some", (accepted > 100) ? 1 : 0, 1);

        // reset in the middle of a stalled stream
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_tag(3'b001);
        bus.res_valid = 1'b1;
        bus.res_x = 16'sd55; bus.res_y = 16'sd66;
        repeat (3) tick();
        check("mid_pre_valid", int'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_out_valid", int'(bus.out_valid), 0);
        check("mid_tag_ready", int'(bus.tag_ready), 1);
        check("mid_res_ready", int'(bus.res_ready), 0);
        check("mid_cos", int'(bus.out_cos), 0);
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", int'(bus.out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
